// File: rtl/mem_pkg.sv
// Shared encodings and default sizing for the memory interface block.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int ADDR_W_DEF         = 8;
  localparam int WAIT_CYCLES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 16;
endpackage

// File: rtl/memory_interface_if.sv
// Controller <-> memory strobe/MFC handshake bundle.
interface memory_interface_if;
  logic        read;
  logic        write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        MFC;
  logic        bus_err;

  modport master (output read, write, addr, wdata, input  rdata, MFC, bus_err);
  modport slave  (input  read, write, addr, wdata, output rdata, MFC, bus_err);
endinterface

// File: rtl/sram_array.sv
// Synchronous single-port storage; registered read, no reset on contents.
module sram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/memory_interface.sv
// Strobe/MFC memory front end with programmable wait states.
// Optional macro MEM_TIMEOUT_EN adds a strobe-release timeout in DONE.
module memory_interface
  import mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int WAIT_CYCLES    = WAIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  memory_interface_if.slave  bus
);
  state_e            state, state_n;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] a_lat, sram_addr;
  logic [15:0]       d_lat, sram_dout, rdata_q;
  logic              bus_err_q;
  logic              start, commit, err;
  logic              strb_op, hold_blk;
  logic              unused_addr;

  localparam int unused_tmo = TIMEOUT_CYCLES;

  assign unused_addr = ^bus.addr;
  assign strb_op     = op_wr ? bus.write : bus.read;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       hold;

  // After a timeout the stuck strobe must be seen low before it can start a new access.
  assign hold_blk = hold & strb_op;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
      hold <= 1'b0;
    end else begin
      tcnt <= (state == DONE) ? tcnt + 1'b1 : '0;
      if (state == DONE && state_n == IDLE && strb_op) hold <= 1'b1;
      else if (state == IDLE && !strb_op)              hold <= 1'b0;
    end
  end
`else
  assign hold_blk = 1'b0;
`endif

  always_comb begin
    state_n = state;
    start   = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: if (!hold_blk) begin
        if (bus.read && bus.write) err = 1'b1;
        else if (bus.read ^ bus.write) begin
          start   = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (!strb_op) state_n = IDLE;
        else if (cnt == '0) begin
          commit  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (!strb_op) state_n = IDLE;
`ifdef MEM_TIMEOUT_EN
        else if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
          err     = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      a_lat     <= '0;
      d_lat     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= err;
      if (start) begin
        cnt   <= 4'(WAIT_CYCLES);
        op_wr <= bus.write;
        a_lat <= bus.addr[ADDR_W-1:0];
        d_lat <= bus.wdata;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && !op_wr) rdata_q <= sram_dout;
    end
  end

  // Array is addressed from the bus while idle so the registered read is ready even with zero wait states.
  assign sram_addr = (state == IDLE) ? bus.addr[ADDR_W-1:0] : a_lat;

  sram_array #(.ADDR_W(ADDR_W), .DATA_W(16)) u_sram (
    .clock (clock),
    .we    (commit & op_wr),
    .addr  (sram_addr),
    .din   (d_lat),
    .dout  (sram_dout)
  );

  assign bus.rdata   = rdata_q;
  assign bus.MFC     = (state == DONE);
  assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_memory_interface.sv
// Randomized bench for memory_interface against a word-array reference model.
module tb_memory_interface;
  localparam int AW = 8;
  localparam int WC = 2;
  localparam int TC = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memory_interface_if bus ();

  memory_interface #(.ADDR_W(AW), .WAIT_CYCLES(WC), .TIMEOUT_CYCLES(TC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] mem_m [2**AW];
  logic [15:0] rdata_m = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Full handshake; called at a negedge with the block idle.
  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d, input int hold);
    int k;
    logic [AW-1:0] w;
    w = a[AW-1:0];
    bus.read  = !wr;
    bus.write = wr;
    bus.addr  = a;
    bus.wdata = d;
    step();
    k = 1;
    bus.addr  = 16'($urandom);
    bus.wdata = 16'($urandom);
    while (!bus.MFC && k < 40) begin
      step();
      k++;
    end
    chk("latency", 32'(k - 1), 32'(WC + 1));
    if (wr) mem_m[w] = d;
    else    rdata_m  = mem_m[w];
    chk(wr ? "rdata_after_write" : "rdata_read", 32'(bus.rdata), 32'(rdata_m));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("mfc_hold", 32'(bus.MFC), 32'd1);
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    step();
    chk("mfc_release", 32'(bus.MFC), 32'd0);
  endtask

  // Strobe dropped after one ACCESS cycle: nothing may commit.
  task automatic abort_op(input bit wr, input logic [15:0] a, input logic [15:0] d);
    bus.read  = !wr;
    bus.write = wr;
    bus.addr  = a;
    bus.wdata = d;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("abort_mfc", 32'(bus.MFC), 32'd0);
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_mfc", 32'(bus.MFC), 32'd0);
    end
    chk("abort_rdata", 32'(bus.rdata), 32'(rdata_m));
  endtask

  task automatic conflict();
    bus.read  = 1'b1;
    bus.write = 1'b1;
    bus.addr  = 16'($urandom);
    step();
    chk("conflict_err", 32'(bus.bus_err), 32'd1);
    chk("conflict_mfc", 32'(bus.MFC), 32'd0);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    step();
    chk("conflict_err_end", 32'(bus.bus_err), 32'd0);
    chk("conflict_rdata", 32'(bus.rdata), 32'(rdata_m));
  endtask

  initial begin
    int k, n, r;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_mfc", 32'(bus.MFC), 32'd0);
    chk("rst_err", 32'(bus.bus_err), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 2**AW; i++)
      access(1'b1, {8'($urandom), 8'(i)}, 16'($urandom), 0);

    access(1'b1, 16'h0005, 16'hA5C3, 0);
    access(1'b0, 16'h0005, 16'h0000, 1);
    chk("wr_rd_0005", 32'(bus.rdata), 32'hA5C3);

    access(1'b1, 16'h0105, 16'h1234, 2);
    access(1'b0, 16'h0005, 16'h0000, 0);
    chk("alias_0105", 32'(bus.rdata), 32'h1234);

    abort_op(1'b0, 16'h0003, 16'h0000);
    abort_op(1'b1, 16'h0003, ~mem_m[3]);
    access(1'b0, 16'h0003, 16'h0000, 0);

    conflict();
    access(1'b0, 16'h0042, 16'h0000, 0);

    // Reset during a write's ACCESS phase.
    bus.write = 1'b1;
    bus.addr  = 16'h0002;
    bus.wdata = 16'hFFFF;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("midrst_mfc", 32'(bus.MFC), 32'd0);
    chk("midrst_rdata", 32'(bus.rdata), 32'h0);
    chk("midrst_err", 32'(bus.bus_err), 32'd0);
    rdata_m   = 16'h0000;
    bus.write = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    access(1'b0, 16'h0002, 16'h0000, 0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      access(1'(r & 1), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
      else if (r < 9) abort_op(1'(r & 1), 16'($urandom), 16'($urandom));
      else            conflict();
    end

`ifdef MEM_TIMEOUT_EN
    bus.read = 1'b1;
    bus.addr = 16'h0010;
    k = 0;
    while (!bus.MFC && k < 40) begin
      step();
      k++;
    end
    chk("tmo_latency", 32'(k - 1), 32'(WC + 1));
    rdata_m = mem_m[16];
    chk("tmo_rdata", 32'(bus.rdata), 32'(rdata_m));
    n = 0;
    while (bus.MFC && n < 40) begin
      n++;
      step();
    end
    chk("tmo_done_cycles", 32'(n), 32'(TC));
    chk("tmo_err", 32'(bus.bus_err), 32'd1);
    chk("tmo_mfc", 32'(bus.MFC), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("tmo_block_mfc", 32'(bus.MFC), 32'd0);
      chk("tmo_block_err", 32'(bus.bus_err), 32'd0);
    end
    bus.read = 1'b0;
    step();
    access(1'b0, 16'h0011, 16'h0000, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 Parameter ADDR_W, default 8, number of low address bits decoded; memory depth is 2^ADDR_W words of 16 bits.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, access latency added before MFC.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, range 1..255, cycles allowed for strobe release; used only with MEM_TIMEOUT_EN.
REQ-004 clock  input  1  single clock; all state changes on posedge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 read  input  1  read strobe from controller, level, held until MFC seen.
REQ-007 write  input  1  write strobe from controller, level, held until MFC seen.
REQ-008 addr  input  16  address from MAR.
REQ-009 wdata  input  16  write data from MDR.
REQ-010 rdata  output  16  read data toward MDR/DBUS.
REQ-011 MFC  output  1  memory-function-complete.
REQ-012 bus_err  output  1  one-cycle error pulse.

Function
REQ-013 FSM states: IDLE, ACCESS, DONE.
REQ-014 IDLE: if exactly one of read/write is 1, latch addr[ADDR_W-1:0], wdata and the operation type, load the wait counter with WAIT_CYCLES, and go to ACCESS.
REQ-015 IDLE with read=1 and write=1 at the same time: stay IDLE, pulse bus_err for 1 cycle, no memory access.
REQ-016 ACCESS: decrement the counter each cycle; when counter==0, commit the access and go to DONE.
REQ-017 Commit read: rdata <= mem[latched addr]. Commit write: mem[latched addr] <= latched wdata, and rdata keeps its value.
REQ-018 Latency: MFC rises WAIT_CYCLES+1 cycles after the first posedge that samples the strobe high, which is 1 cycle when WAIT_CYCLES=0.
REQ-019 DONE: MFC=1 and is held until the active strobe is sampled low, then go to IDLE with MFC=0 in the next cycle.
REQ-020 MFC=0 in the IDLE and ACCESS states.
REQ-021 Strobe dropped during ACCESS: abort, return to IDLE, no commit, MFC never asserted.
REQ-022 Address bits above ADDR_W-1 are ignored, so addresses alias (wrap) modulo 2^ADDR_W.
REQ-023 addr/wdata changes after latching have no effect on the access in flight.
REQ-024 rdata holds the last committed read value until the next read commit.
REQ-025 A new access can begin no earlier than the cycle after the block returns to IDLE, so back-to-back accesses have a minimum 1-cycle IDLE gap.

Reset
REQ-026 While reset=0, all of the following hold immediately and asynchronously: state=IDLE, MFC=0, bus_err=0, rdata=16'h0000, counter=0.
REQ-027 Reset asserted during ACCESS or DONE aborts the access, and no write is committed afterward.
REQ-028 Memory array contents are not cleared by reset.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN defined: in DONE, count cycles; if the strobe is still high after TIMEOUT_CYCLES cycles, pulse bus_err 1 cycle, drop MFC and go to IDLE.
REQ-030 After a timeout, the block does not re-enter ACCESS until the strobe has been sampled low at least once.
REQ-031 Macro MEM_TIMEOUT_EN undefined: DONE waits indefinitely for strobe release, no timeout counter is built, and bus_err is driven only by REQ-015.

Structure
REQ-032 Shared package mem_pkg: state encoding constants (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), default ADDR_W, default WAIT_CYCLES, default TIMEOUT_CYCLES.
REQ-033 One sub-module, sram_array: synchronous single-port 16-bit array with we, addr, din, dout; no reset.
REQ-034 FSM, wait counter and timeout counter live in memory_interface.

Verification
REQ-035 Write then read, WAIT_CYCLES=2: write=1, addr=16'h0005, wdata=16'hA5C3 -> MFC high 3 cycles after strobe sampled, drop write -> MFC low next cycle; then read addr=16'h0005 -> rdata=16'hA5C3 when MFC rises.
REQ-036 Alias: write 16'h1234 to addr=16'h0105 (ADDR_W=8); read addr=16'h0005 -> rdata=16'h1234.
REQ-037 Abort: read=1 to addr=16'h0003 and drop it after 1 cycle of ACCESS -> MFC stays 0 and rdata unchanged; a write aborted the same way leaves memory unchanged.
REQ-038 Conflict: read=1 and write=1 together -> bus_err 1-cycle pulse, MFC stays 0, state stays IDLE.
REQ-039 Reset mid-op: assert reset=0 during ACCESS of a write of 16'hFFFF to addr 2 -> MFC=0 and rdata=0 immediately; a subsequent read of addr 2 returns the prior contents.
REQ-040 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4: hold read high after MFC -> bus_err pulse after 4 DONE cycles, MFC drops, no new access until read has been sampled low.
